stump_reg_dump: RTL and testbench
=================================

// Module: stump_reg_dump
// PURPOSE
//  Debug read-out engine for the Stump register bank's observability port C.
//  On a start pulse it walks the selected registers via read_addr_C and snapshots
//  each value. It streams them out as a byte stream over a valid/ready handshake
//  towards the Perentie host link. Read-only: never drives the bank's write port.
// PARAMETERS
//  NUM_REGS  8    registers in bank (mask width); index width fixed at 3 bits
//  DATA_W    16   register width; fixed 16, two payload bytes per register
//  TAG_HI    5'b10100  upper 5 bits of per-register tag byte
// PORTS
//  clk          in   1   system clock, all state on posedge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   1-cycle request; sampled only in IDLE
//  reg_mask     in   8   bit i=1 -> dump register i; sampled with start
//  busy         out  1   high from cycle after accepted start until done
//  done         out  1   1-cycle pulse after final byte handshake
//  read_addr_C  out  3   registered address to bank port C
//  read_data_C  in   16  combinational read data from bank port C
//  out_data     out  8   stream byte
//  out_valid    out  1   byte available
//  out_ready    in   1   sink accepts; transfer = out_valid & out_ready
//  out_last     out  1   marks final byte of dump, valid with out_valid
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, out_valid=0, out_last=0, out_data=8'h00,
//   read_addr_C=3'd0, pending mask=0, checksum=0. Reset mid-dump aborts with no
//   further bytes.
//  States: IDLE, LOAD, TAG, HI, LO, CSUM (CSUM only with macro), FIN.
//  IDLE: start & mask!=0 -> latch pending=reg_mask, read_addr_C=lowest set bit,
//   clear that bit in pending, -> LOAD. start & mask==0 -> FIN without macro,
//   CSUM with macro. start outside IDLE is ignored.
//  LOAD: one cycle with read_addr_C stable; on the edge, snapshot read_data_C
//   into a 16-bit holding reg -> TAG. Later bank writes do not alter the
//   snapshot.
//  TAG/HI/LO: out_valid=1, out_data = {TAG_HI,idx}, snap[15:8], snap[7:0].
//   Each advances only on a transfer; out_data, out_valid and out_last are held
//   stable while out_valid & !out_ready. No bubble between TAG, HI and LO.
//  After LO transfer: pending!=0 -> read_addr_C=next lowest set bit, clear it,
//   -> LOAD. Otherwise -> CSUM (macro) or FIN.
//  out_last: asserted on the final byte only. Without the macro this is the LO
//   byte of the last register. With the macro it is the CSUM byte.
//  FIN: done=1 for one cycle, busy=0 after it -> IDLE; start here is ignored.
//  busy=1 in LOAD..FIN inclusive.
//  Latency: accepted start edge -> out_valid high 2 cycles later; between
//   registers, 1 LOAD cycle of bubble.
//  Order: ascending register index. R0 reads 16'h0000 from the bank and is sent
//   normally.
// CONFIGURATION
//  STUMP_DUMP_CSUM_EN defined: 8-bit checksum = sum mod 256 of every byte sent
//   (tags+payload), cleared on accepted start. Emitted as a final byte in CSUM
//   with out_last=1. mask==0 sends the single byte 8'h00 with out_last.
//  Undefined: no CSUM state or checksum reg. mask==0 emits no bytes; done
//   pulses 1 cycle after the start edge.
// TESTING
//  1 reset then idle: all outputs at reset values, no out_valid for 20 cycles
//    with start=0.
//  2 r7=16'h1234, mask=8'h80, out_ready=1 -> bytes A7,12,34; out_last on 34;
//    done 1 cycle later; CSUM_EN adds byte 8'hED with out_last.
//  3 mask=8'h05, r2=16'hBEEF, out_ready toggling 1010.. -> A0,00,00,A2,BE,EF;
//    each byte held steady while stalled.
//  4 mask=8'h80, bank r7 rewritten to 16'hFFFF after LOAD -> still sends 12,34
//    (snapshot).
//  5 mask=8'h00 -> no bytes, done 1 cycle after start (CSUM_EN: single 00,
//    last); second start during busy is ignored.
//  6 rst asserted while HI pending under stall -> out_valid=0 next cycle,
//    busy=0; new start dumps cleanly.

Source files
------------

// File: rtl/stump_reg_dump.sv
// stump_reg_dump: debug read-out engine for the Stump register bank port C.
// On an accepted start it walks the registers selected by reg_mask in
// ascending order. It snapshots each one through read_addr_C/read_data_C and
// streams a tag byte plus two payload bytes per register over a valid/ready
// byte interface. It never writes the bank.
//
// Build option: define STUMP_DUMP_CSUM_EN to append a checksum byte. The byte
// is the 8-bit sum of every byte sent, and it carries out_last.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start, reg_mask  dump request and register select mask (sampled in IDLE)
//   busy, done       engine active; 1-cycle completion pulse
//   read_addr_C      registered bank read address
//   read_data_C      combinational bank read data
//   out_data/out_valid/out_ready/out_last   byte stream to the host link
module stump_reg_dump #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DATA_W   = 16,
  parameter logic [4:0]  TAG_HI   = 5'b10100,
  localparam int unsigned IDX_W   = 3,
  localparam int unsigned BYTE_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_REGS-1:0] reg_mask,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    read_addr_C,
  input  logic [DATA_W-1:0]   read_data_C,
  output logic [BYTE_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TAG,
    S_HI,
    S_LO,
`ifdef STUMP_DUMP_CSUM_EN
    S_CSUM,
`endif
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   snap_q, snap_d;
  logic [BYTE_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer;
`ifdef STUMP_DUMP_CSUM_EN
  logic [BYTE_W-1:0]   csum_q, csum_d;
`endif

  // Index of the lowest set bit; callers only use it on a nonzero mask.
  function automatic logic [IDX_W-1:0] low_idx(input logic [NUM_REGS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Mask with the given index cleared.
  function automatic logic [NUM_REGS-1:0] clr_bit(input logic [NUM_REGS-1:0] m,
                                                  input logic [IDX_W-1:0]    idx);
    return m & ~(NUM_REGS'(1) << idx);
  endfunction

  assign xfer = out_valid_q & out_ready;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    addr_d      = addr_q;
    snap_d      = snap_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef STUMP_DUMP_CSUM_EN
    csum_d      = xfer ? csum_q + out_data_q : csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef STUMP_DUMP_CSUM_EN
          csum_d = '0;
`endif
          if (|reg_mask) begin
            addr_d    = low_idx(reg_mask);
            pending_d = clr_bit(reg_mask, low_idx(reg_mask));
            state_d   = S_LOAD;
          end else begin
`ifdef STUMP_DUMP_CSUM_EN
            // Empty dump still sends the (zero) checksum byte.
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_last_d  = 1'b1;
            state_d     = S_CSUM;
`else
            done_d  = 1'b1;
            state_d = S_FIN;
`endif
          end
        end
      end

      S_LOAD: begin
        // Snapshot so later bank writes cannot change bytes in flight.
        snap_d      = read_data_C;
        out_valid_d = 1'b1;
        out_data_d  = {TAG_HI, addr_q};
        out_last_d  = 1'b0;
        state_d     = S_TAG;
      end

      S_TAG: begin
        if (xfer) begin
          out_data_d = snap_q[DATA_W-1 -: BYTE_W];
          state_d    = S_HI;
        end
      end

      S_HI: begin
        if (xfer) begin
          out_data_d = snap_q[BYTE_W-1:0];
`ifdef STUMP_DUMP_CSUM_EN
          out_last_d = 1'b0;
`else
          out_last_d = (pending_q == '0);
`endif
          state_d    = S_LO;
        end
      end

      S_LO: begin
        if (xfer) begin
          if (pending_q != '0) begin
            addr_d      = low_idx(pending_q);
            pending_d   = clr_bit(pending_q, low_idx(pending_q));
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_LOAD;
          end else begin
`ifdef STUMP_DUMP_CSUM_EN
            // Checksum must include the LO byte being accepted now.
            out_data_d = csum_q + out_data_q;
            out_last_d = 1'b1;
            state_d    = S_CSUM;
`else
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = S_FIN;
`endif
          end
        end
      end

`ifdef STUMP_DUMP_CSUM_EN
      S_CSUM: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = S_FIN;
        end
      end
`endif

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      addr_q      <= '0;
      snap_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef STUMP_DUMP_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      addr_q      <= addr_d;
      snap_q      <= snap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef STUMP_DUMP_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign read_addr_C = addr_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_stump_reg_dump.sv
// Testbench for stump_reg_dump: a bank model drives port C, and a queue-based
// reference builds the expected byte stream for each dump.
module tb_stump_reg_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  reg_mask;
  logic        busy;
  logic        done;
  logic [2:0]  read_addr_C;
  logic [15:0] read_data_C;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  logic [15:0] bank [8];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  // R0 is hard-wired to zero in the bank.
  assign read_data_C = (read_addr_C == 3'd0) ? 16'h0000 : bank[read_addr_C];

  stump_reg_dump dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reg_mask   (reg_mask),
    .busy       (busy),
    .done       (done),
    .read_addr_C(read_addr_C),
    .read_data_C(read_data_C),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One dump: mode 0 = ready always, 1 = ready toggling 1010.., 2 = random.
  // extra = pulse a second start while the engine is busy.
  task automatic run_dump(input logic [7:0] mask, input int mode, input bit extra);
    logic [7:0]  exp_q[$];
    int          tag_q[$];
    logic [7:0]  sum;
    logic [15:0] v;
    int          k;
    int          exp_v;
    int          last_xfer_k;
    bit          got_done;
    bit          r;
    bit          rtog;
    bit          popped;
    bit          prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;

    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        v = (i == 0) ? 16'h0000 : bank[i];
        exp_q.push_back({5'b10100, 3'(i)}); tag_q.push_back(i);
        exp_q.push_back(v[15:8]);           tag_q.push_back(-1);
        exp_q.push_back(v[7:0]);            tag_q.push_back(-1);
      end
    end
`ifdef STUMP_DUMP_CSUM_EN
    sum = 8'h00;
    foreach (exp_q[j]) sum = sum + exp_q[j];
    exp_q.push_back(sum); tag_q.push_back(-1);
`endif

    @(negedge clk);
    start     = 1'b1;
    reg_mask  = mask;
    out_ready = 1'b0;
    @(negedge clk);

    exp_v       = (exp_q.size() > 0 && tag_q[0] < 0) ? 1 : 0;
    got_done    = 1'b0;
    last_xfer_k = 0;
    rtog        = 1'b0;
    prev_stall  = 1'b0;
    prev_data   = 8'h00;
    prev_last   = 1'b0;
    k           = 1;

    while (!got_done && k <= 400) begin
      if (k > 1) @(negedge clk);
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("valid_timing", 32'(out_valid), 32'(exp_v));
      if (prev_stall) begin
        check_eq("hold_data", 32'(out_data), 32'(prev_data));
        check_eq("hold_last", 32'(out_last), 32'(prev_last));
      end

      case (mode)
        0:       r = 1'b1;
        1:       begin rtog = !rtog; r = rtog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      start     = extra && (k == 1);
      reg_mask  = (extra && k == 1) ? 8'hFF : 8'($urandom);
      popped    = 1'b0;

      if (done) begin
        got_done = 1'b1;
        check_eq("done_all_sent", 32'(exp_q.size()), 32'd0);
        check_eq("done_latency", 32'(k), 32'(last_xfer_k + 1));
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_byte", 32'(out_valid), 32'd0);
        end else begin
          check_eq("data", 32'(out_data), 32'(exp_q[0]));
          check_eq("last", 32'(out_last), 32'(exp_q.size() == 1));
          // Scribble the bank once the register is on the wire.
          if (tag_q[0] > 0) bank[tag_q[0]] = 16'hFFFF;
          if (r) begin
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
            popped      = 1'b1;
            last_xfer_k = k;
          end
        end
      end

      prev_stall = out_valid && !r && !done;
      prev_data  = out_data;
      prev_last  = out_last;
      if (popped) exp_v = (exp_q.size() == 0) ? 0 : ((tag_q[0] >= 0) ? 0 : 1);
      else        exp_v = (exp_q.size() > 0) ? 1 : 0;
      k++;
    end

    if (!got_done) check_eq("done_timeout", 32'(got_done), 32'd1);

    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
      check_eq("idle_valid", 32'(out_valid), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    reg_mask  = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bank[i] = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values, then quiet idle.
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'h00);
    check_eq("rst_addr", 32'(read_addr_C), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle20_valid", 32'(out_valid), 32'd0);
      check_eq("idle20_busy", 32'(busy), 32'd0);
    end

    // Single top register, free-flowing sink.
    bank[7] = 16'h1234;
    run_dump(8'h80, 0, 1'b0);

    // R0 plus R2 with a toggling sink.
    bank[0] = 16'hDEAD;
    bank[2] = 16'hBEEF;
    run_dump(8'h05, 1, 1'b0);

    // Snapshot: r7 is overwritten once its tag is visible.
    bank[7] = 16'h1234;
    run_dump(8'h80, 1, 1'b0);

    // Empty mask, plus a second start while busy.
    run_dump(8'h00, 0, 1'b1);

    // Reset while the HI byte is stalled.
    bank[7] = 16'h1234;
    @(negedge clk);
    start = 1'b1; reg_mask = 8'h80; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("r6_tag_valid", 32'(out_valid), 32'd1);
    check_eq("r6_tag", 32'(out_data), 32'hA7);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("r6_hi", 32'(out_data), 32'h12);
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("r6_hi_held", 32'(out_data), 32'h12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("r6_valid", 32'(out_valid), 32'd0);
    check_eq("r6_busy", 32'(busy), 32'd0);
    check_eq("r6_done", 32'(done), 32'd0);
    check_eq("r6_last", 32'(out_last), 32'd0);
    check_eq("r6_data", 32'(out_data), 32'h00);
    check_eq("r6_addr", 32'(read_addr_C), 32'd0);
    bank[7] = 16'h5A3C;
    bank[1] = 16'h0F0F;
    run_dump(8'h82, 2, 1'b0);

    // Randomized dumps.
    for (int n = 0; n < 30; n++) begin
      for (int i = 1; i < 8; i++) bank[i] = 16'($urandom);
      run_dump(8'($urandom), 2, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
